// File: rtl/uart_reg_bridge.sv
// UART command responder: pops 'W'/'R' frames from the receive FIFO, runs one
// register-bus access per frame and pushes a single response byte.
module uart_reg_bridge #(
  parameter int unsigned ADDR_W        = 8,
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned BUS_TIMEOUT   = 255,
  parameter int unsigned FRAME_TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_empty,
  output logic              rd_uart,
  output logic [7:0]        tx_data,
  output logic              wr_uart,
  input  logic              tx_full,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_we,
  output logic              reg_req,
  input  logic              reg_ack,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              busy,
  output logic              frame_err,
  output logic              bus_err
);

  localparam int unsigned BCW = $clog2(BUS_TIMEOUT + 1);
  localparam int unsigned FCW = $clog2(FRAME_TIMEOUT + 1);

  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] ACK   = 8'h06;
  localparam logic [7:0] NAK   = 8'h15;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] GET_ADDR = 3'd1;
  localparam logic [2:0] GET_DATA = 3'd2;
  localparam logic [2:0] BUS_REQ  = 3'd3;
  localparam logic [2:0] SEND     = 3'd4;

  logic [2:0]     state, state_nxt;
  logic           is_write;
  logic           ferr_pend;
  logic [7:0]     resp;
  logic [BCW-1:0] bus_cnt;
  logic [FCW-1:0] frame_cnt;

  logic       in_frame, pop, cmd_ok, fto, ack_hit, bto, bus_done, push;
  logic [7:0] bus_resp;

  // rd_uart is registered, so a pop is held off while the previous strobe is
  // still high; otherwise a stale rx_empty could trigger a second pop.
  assign in_frame = (state == GET_ADDR) || (state == GET_DATA);
  assign pop      = (in_frame || state == IDLE) && !rx_empty && !rd_uart;
  assign cmd_ok   = (rx_data == CMD_W) || (rx_data == CMD_R);
  assign fto      = in_frame && !pop && (frame_cnt == FCW'(FRAME_TIMEOUT - 1));
  assign ack_hit  = (state == BUS_REQ) && reg_req && reg_ack;
  assign bto      = (state == BUS_REQ) && reg_req && !reg_ack &&
                    (bus_cnt == BCW'(BUS_TIMEOUT - 1));
  assign bus_done = ack_hit || bto;
  assign bus_resp = ack_hit ? (is_write ? ACK : 8'(reg_rdata)) : NAK;
  assign push     = !tx_full && !wr_uart && ((state == SEND) || bus_done);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (pop) state_nxt = cmd_ok ? GET_ADDR : SEND;
      GET_ADDR: if (pop) state_nxt = is_write ? GET_DATA : BUS_REQ;
                else if (fto) state_nxt = IDLE;
      GET_DATA: if (pop) state_nxt = BUS_REQ;
                else if (fto) state_nxt = IDLE;
      BUS_REQ:  if (bus_done) state_nxt = SEND;
      SEND:     if (wr_uart) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rd_uart   <= 1'b0;
      wr_uart   <= 1'b0;
      tx_data   <= '0;
      reg_req   <= 1'b0;
      reg_we    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
      bus_err   <= 1'b0;
      is_write  <= 1'b0;
      ferr_pend <= 1'b0;
      resp      <= '0;
      bus_cnt   <= '0;
      frame_cnt <= '0;
    end else begin
      state     <= state_nxt;
      busy      <= (state_nxt != IDLE);
      rd_uart   <= pop;
      wr_uart   <= push;
      ferr_pend <= pop && (state == IDLE) && !cmd_ok;
      frame_err <= ferr_pend || fto;
      bus_err   <= bto;
      // A bus completion with room in the TX FIFO pushes straight away; SEND
      // then only waits out the strobe cycle.
      if (push) tx_data <= (state == SEND) ? resp : bus_resp;

      if (pop || !in_frame || fto) frame_cnt <= '0;
      else                         frame_cnt <= frame_cnt + FCW'(1);

      case (state)
        IDLE: if (pop) begin
          is_write <= (rx_data == CMD_W);
          resp     <= NAK;
        end
        GET_ADDR: if (pop) reg_addr  <= ADDR_W'(rx_data);
        GET_DATA: if (pop) reg_wdata <= DATA_W'(rx_data);
        BUS_REQ: begin
          if (!reg_req) begin
            reg_req <= 1'b1;
            reg_we  <= is_write;
            bus_cnt <= '0;
          end else if (bus_done) begin
            reg_req <= 1'b0;
            resp    <= bus_resp;
          end else begin
            bus_cnt <= bus_cnt + BCW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Directed bench for uart_reg_bridge: FIFO and bus responder driven inline,
// protocol counters kept by a negedge monitor.
module tb_uart_reg_bridge;

  localparam int BT = 20;
  localparam int FT = 60;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data;
  logic       rx_empty;
  logic       rd_uart;
  logic [7:0] tx_data;
  logic       wr_uart;
  logic       tx_full = 1'b0;
  logic [7:0] reg_addr, reg_wdata;
  logic       reg_we, reg_req;
  logic       reg_ack = 1'b0;
  logic [7:0] reg_rdata = 8'h00;
  logic       busy, frame_err, bus_err;

  logic [7:0] rx_mem [32];
  int rx_wr = 0, rx_rd = 0;

  int n_assert = 0, n_fail = 0;
  int cyc = 0, pops = 0, pushes = 0, pop_empty = 0, push_full = 0;
  int req_cyc_cnt = 0, req_start_cyc = 0, last_pop_cyc = 0;
  int ferr_cnt = 0, ferr_cyc = 0, berr_cnt = 0;
  logic req_prev = 1'b0, full_prev = 1'b0, empty_prev = 1'b1;
  int p0, r0, f0, b0, q0;

  assign rx_empty = (rx_rd == rx_wr);
  assign rx_data  = rx_mem[rx_rd[4:0]];

  uart_reg_bridge #(
    .ADDR_W(8), .DATA_W(8), .BUS_TIMEOUT(BT), .FRAME_TIMEOUT(FT)
  ) dut (
    .clk(clk), .reset(reset),
    .rx_data(rx_data), .rx_empty(rx_empty), .rd_uart(rd_uart),
    .tx_data(tx_data), .wr_uart(wr_uart), .tx_full(tx_full),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we),
    .reg_req(reg_req), .reg_ack(reg_ack), .reg_rdata(reg_rdata),
    .busy(busy), .frame_err(frame_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rd_uart) begin
      pops <= pops + 1;
      last_pop_cyc <= cyc;
      if (empty_prev) pop_empty <= pop_empty + 1;
      else if (rx_rd != rx_wr) rx_rd <= rx_rd + 1;
    end
    if (wr_uart) begin
      pushes <= pushes + 1;
      if (full_prev) push_full <= push_full + 1;
    end
    if (reg_req) req_cyc_cnt <= req_cyc_cnt + 1;
    if (reg_req && !req_prev) req_start_cyc <= cyc;
    if (frame_err) begin
      ferr_cnt <= ferr_cnt + 1;
      ferr_cyc <= cyc;
    end
    if (bus_err) berr_cnt <= berr_cnt + 1;
    req_prev   <= reg_req;
    full_prev  <= tx_full;
    empty_prev <= rx_empty;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push_rx(input logic [7:0] b);
    rx_mem[rx_wr[4:0]] = b;
    rx_wr++;
  endtask

  task automatic wait_req(input int lim);
    for (int i = 0; i < lim && reg_req !== 1'b1; i++) tick(1);
  endtask

  initial begin
    // reset values
    tick(2);
    check("rst_ctl", 32'({rd_uart, wr_uart, reg_req, reg_we, busy, frame_err, bus_err}), 0);
    check("rst_tx", 32'(tx_data), 0);
    check("rst_bus", 32'({reg_addr, reg_wdata}), 0);
    reset = 1'b0;
    tick(1);

    // write frame, ack one cycle after req
    p0 = pushes; r0 = req_cyc_cnt;
    push_rx(8'h57); push_rx(8'h10); push_rx(8'hA5);
    wait_req(20);
    check("wr_req", 32'(reg_req), 1);
    check("wr_addr", 32'(reg_addr), 'h10);
    check("wr_wdata", 32'(reg_wdata), 'hA5);
    check("wr_we", 32'(reg_we), 1);
    check("wr_busy", 32'(busy), 1);
    tick(1); reg_ack = 1'b1;
    tick(1); reg_ack = 1'b0;
    check("wr_req_drop", 32'(reg_req), 0);
    check("wr_push", 32'(wr_uart), 1);
    check("wr_resp", 32'(tx_data), 'h06);
    check("wr_req_latency", req_start_cyc - last_pop_cyc, 1);
    tick(1);
    check("wr_busy_end", 32'(busy), 0);
    check("wr_one_push", pushes - p0, 1);
    check("wr_req_cycles", req_cyc_cnt - r0, 2);

    // read frame, zero-wait ack
    reg_rdata = 8'h3C;
    push_rx(8'h52); push_rx(8'h22);
    wait_req(20);
    check("rd_req", 32'(reg_req), 1);
    check("rd_we", 32'(reg_we), 0);
    check("rd_addr", 32'(reg_addr), 'h22);
    reg_ack = 1'b1;
    tick(1); reg_ack = 1'b0;
    check("rd_req_drop", 32'(reg_req), 0);
    check("rd_push", 32'(wr_uart), 1);
    check("rd_resp", 32'(tx_data), 'h3C);
    tick(2);

    // unknown command then a normal write
    r0 = req_cyc_cnt; f0 = ferr_cnt;
    push_rx(8'h41);
    tick(1);
    check("bad_pop", 32'(rd_uart), 1);
    tick(1);
    check("bad_ferr", 32'(frame_err), 1);
    check("bad_push", 32'(wr_uart), 1);
    check("bad_nak", 32'(tx_data), 'h15);
    tick(1);
    check("bad_ferr_pulse", 32'(frame_err), 0);
    check("bad_idle", 32'(busy), 0);
    check("bad_no_req", req_cyc_cnt - r0, 0);
    check("bad_ferr_cnt", ferr_cnt - f0, 1);
    push_rx(8'h57); push_rx(8'h33); push_rx(8'h5A);
    wait_req(20);
    check("after_bad_addr", 32'(reg_addr), 'h33);
    check("after_bad_wdata", 32'(reg_wdata), 'h5A);
    reg_ack = 1'b1;
    tick(1); reg_ack = 1'b0;
    check("after_bad_resp", 32'({wr_uart, tx_data}), 'h106);
    tick(2);

    // read with no ack: bus timeout
    reg_rdata = 8'h00; b0 = berr_cnt;
    push_rx(8'h52); push_rx(8'h44);
    wait_req(20);
    r0 = req_cyc_cnt;
    for (int i = 0; i < 40 && reg_req === 1'b1; i++) tick(1);
    check("bto_req_drop", 32'(reg_req), 0);
    check("bto_req_cycles", req_cyc_cnt - r0, BT);
    check("bto_bus_err", 32'(bus_err), 1);
    check("bto_nak", 32'({wr_uart, tx_data}), 'h115);
    tick(1);
    check("bto_pulse", 32'(bus_err), 0);
    tick(1);

    // ack on the terminal cycle wins
    reg_rdata = 8'h99; b0 = berr_cnt;
    push_rx(8'h52); push_rx(8'h45);
    wait_req(20);
    tick(BT - 1);
    check("term_req_held", 32'(reg_req), 1);
    reg_ack = 1'b1;
    tick(1); reg_ack = 1'b0;
    check("term_no_bus_err", 32'(bus_err), 0);
    check("term_data", 32'({wr_uart, tx_data}), 'h199);
    check("term_req_drop", 32'(reg_req), 0);
    tick(2);
    check("term_berr_cnt", berr_cnt - b0, 0);

    // frame timeout after W, addr
    p0 = pushes; r0 = req_cyc_cnt; f0 = ferr_cnt;
    push_rx(8'h57); push_rx(8'h10);
    for (int i = 0; i < 200 && frame_err !== 1'b1; i++) tick(1);
    check("fto_ferr", 32'(frame_err), 1);
    check("fto_idle", 32'(busy), 0);
    tick(1);
    check("fto_cycles", ferr_cyc - last_pop_cyc, FT);
    check("fto_no_push", pushes - p0, 0);
    check("fto_no_req", req_cyc_cnt - r0, 0);
    check("fto_ferr_cnt", ferr_cnt - f0, 1);

    // transmit FIFO full after a write
    tx_full = 1'b1; p0 = pushes;
    push_rx(8'h57); push_rx(8'h01); push_rx(8'h02);
    wait_req(20);
    reg_ack = 1'b1;
    tick(1); reg_ack = 1'b0;
    check("full_req_drop", 32'(reg_req), 0);
    check("full_no_push", 32'(wr_uart), 0);
    tick(48);
    check("full_held_no_push", pushes - p0, 0);
    check("full_busy", 32'(busy), 1);
    tx_full = 1'b0;
    tick(1);
    check("full_release_push", 32'({wr_uart, tx_data}), 'h106);
    tick(1);
    check("full_busy_end", 32'(busy), 0);

    // reset mid GET_DATA
    push_rx(8'h57); push_rx(8'h07);
    tick(6);
    check("mid_busy", 32'(busy), 1);
    check("mid_addr", 32'(reg_addr), 'h07);
    reset = 1'b1;
    #1;
    check("mid_rst_ctl", 32'({rd_uart, wr_uart, reg_req, reg_we, busy, frame_err, bus_err}), 0);
    check("mid_rst_data", 32'({tx_data, reg_addr, reg_wdata}), 0);
    q0 = pops; p0 = pushes;
    push_rx(8'h55);
    tick(4);
    check("mid_rst_no_pop", pops - q0, 0);
    check("mid_rst_no_push", pushes - p0, 0);
    rx_wr = rx_rd;
    reset = 1'b0;
    tick(1);
    push_rx(8'h57); push_rx(8'h20); push_rx(8'h77);
    wait_req(20);
    check("post_rst_bus", 32'({reg_we, reg_addr, reg_wdata}), 'h12077);
    reg_ack = 1'b1;
    tick(1); reg_ack = 1'b0;
    check("post_rst_resp", 32'({wr_uart, tx_data}), 'h106);
    tick(2);

    // reset while the request is outstanding
    push_rx(8'h52); push_rx(8'h5A);
    wait_req(20);
    check("req_rst_pre", 32'(reg_req), 1);
    reset = 1'b1;
    #1;
    check("req_rst_async", 32'({reg_req, busy}), 0);
    p0 = pushes;
    tick(3);
    reset = 1'b0;
    tick(5);
    check("req_rst_no_resp", pushes - p0, 0);
    check("req_rst_idle", 32'({reg_req, busy}), 0);

    check("never_push_full", push_full, 0);
    check("never_pop_empty", pop_empty, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
